// File: rtl/matrix_collector.sv
// matrix_collector
// Receives matrix elements over a valid/ready stream in row-major order,
// generates its own (row, column) write position, and stores the elements in
// an internal register array. After the final element it holds the matrix
// (FULL) and serves random-access reads until the consumer releases it with
// clear_i.
//
// Ports
//   clock_i       single clock, rising edge
//   reset_i       synchronous, active-high; also zeroes the array
//   in_valid_i    producer has an element
//   in_ready_o    collector can accept (depends on state only)
//   in_data_i     element value
//   in_last_i     producer marks the final element of the matrix
//   clear_i       release FULL / abort the current fill
//   wr_i_o        row index of the next element to be accepted
//   wr_j_o        column index of the next element to be accepted
//   full_o        matrix complete, contents stable
//   frame_done_o  one-cycle pulse on the cycle full_o rises
//   err_last_o    sticky: in_last_i disagreed with the internal position
//   rd_i_i        read row
//   rd_j_i        read column
//   rd_data_o     registered read data (0 for out-of-range reads)
//
// state  | meaning
// S_FILL | accepting elements, write position advancing
// S_FULL | matrix complete, array frozen, waiting for clear_i

module matrix_collector #(
  parameter int SIZELin    = 3,
  parameter int SIZECol    = 3,
  parameter int WIDTH_BIT  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic                  clear_i,
  output logic [WIDTH_BIT-1:0]  wr_i_o,
  output logic [WIDTH_BIT-1:0]  wr_j_o,
  output logic                  full_o,
  output logic                  frame_done_o,
  output logic                  err_last_o,
  input  logic [WIDTH_BIT-1:0]  rd_i_i,
  input  logic [WIDTH_BIT-1:0]  rd_j_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int ROWS = SIZELin + 1;
  localparam int COLS = SIZECol + 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [WIDTH_BIT-1:0] LAST_ROW = WIDTH_BIT'(SIZELin);
  localparam logic [WIDTH_BIT-1:0] LAST_COL = WIDTH_BIT'(SIZECol);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_BIT-1:0]   wr_i_q, wr_i_d;
  logic [WIDTH_BIT-1:0]   wr_j_q, wr_j_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_last_q, err_last_d;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic [DATA_WIDTH-1:0]  mem_q [ROWS][COLS];

  logic accept;
  logic at_last_col;
  logic at_final;
  logic rd_in_range;

  always_comb begin
    accept       = in_valid_i && (state_q == S_FILL) && !clear_i;
    at_last_col  = (wr_j_q == LAST_COL);
    at_final     = at_last_col && (wr_i_q == LAST_ROW);
    rd_in_range  = (rd_i_i <= LAST_ROW) && (rd_j_i <= LAST_COL);

    state_d      = state_q;
    wr_i_d       = wr_i_q;
    wr_j_d       = wr_j_q;
    frame_done_d = 1'b0;
    err_last_d   = err_last_q;

    // clear_i takes priority over a same-cycle beat: the beat is dropped.
    if (clear_i) begin
      state_d    = S_FILL;
      wr_i_d     = '0;
      wr_j_d     = '0;
      err_last_d = 1'b0;
    end else if (accept) begin
      if (at_final) begin
        // A missing in_last on the final element is flagged but the matrix
        // is still considered complete.
        state_d      = S_FULL;
        wr_i_d       = '0;
        wr_j_d       = '0;
        frame_done_d = 1'b1;
        if (!in_last_i) err_last_d = 1'b1;
      end else if (in_last_i) begin
        // Early in_last: drop the truncated matrix and resync to (0,0).
        // Cells already written are left as they are.
        wr_i_d     = '0;
        wr_j_d     = '0;
        err_last_d = 1'b1;
      end else if (at_last_col) begin
        wr_j_d = '0;
        wr_i_d = wr_i_q + 1'b1;
      end else begin
        wr_j_d = wr_j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_FILL;
      wr_i_q       <= '0;
      wr_j_q       <= '0;
      frame_done_q <= 1'b0;
      err_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_i_q       <= wr_i_d;
      wr_j_q       <= wr_j_d;
      frame_done_q <= frame_done_d;
      err_last_q   <= err_last_d;
    end
  end

  // Write position is always within the array, so only the low index bits
  // are needed to address it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      mem_q[wr_i_q[RW-1:0]][wr_j_q[CW-1:0]] <= in_data_i;
    end
  end

  // Reads see the array before any same-edge write.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_in_range) begin
      rd_data_q <= mem_q[rd_i_i[RW-1:0]][rd_j_i[CW-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign in_ready_o   = (state_q == S_FILL);
  assign full_o       = (state_q == S_FULL);
  assign wr_i_o       = wr_i_q;
  assign wr_j_o       = wr_j_q;
  assign frame_done_o = frame_done_q;
  assign err_last_o   = err_last_q;
  assign rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_matrix_collector.sv
module tb_matrix_collector;

  localparam int SL = 2;
  localparam int SC = 2;
  localparam int W  = 8;
  localparam int DW = 8;
  localparam int NC = (SL + 1) * (SC + 1);

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          in_last_i;
  logic          clear_i;
  logic [W-1:0]  wr_i_o;
  logic [W-1:0]  wr_j_o;
  logic          full_o;
  logic          frame_done_o;
  logic          err_last_o;
  logic [W-1:0]  rd_i_i;
  logic [W-1:0]  rd_j_i;
  logic [DW-1:0] rd_data_o;

  always #5 clock_i = ~clock_i;

  matrix_collector #(
    .SIZELin(SL), .SIZECol(SC), .WIDTH_BIT(W), .DATA_WIDTH(DW)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .clear_i(clear_i), .wr_i_o(wr_i_o), .wr_j_o(wr_j_o), .full_o(full_o),
    .frame_done_o(frame_done_o), .err_last_o(err_last_o), .rd_i_i(rd_i_i),
    .rd_j_i(rd_j_i), .rd_data_o(rd_data_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: matrix as a flat row-major array, position as a count
  logic [DW-1:0] m_mem [NC];
  bit            m_full;
  bit            m_err;
  bit            m_fd;
  int            m_pos;
  logic [DW-1:0] m_rd;

  function automatic logic [W-1:0] exp_i();
    return W'(m_pos / (SC + 1));
  endfunction

  function automatic logic [W-1:0] exp_j();
    return W'(m_pos % (SC + 1));
  endfunction

  task automatic model_update();
    logic [DW-1:0] rd_next;
    if (int'(rd_i_i) <= SL && int'(rd_j_i) <= SC)
      rd_next = m_mem[int'(rd_i_i) * (SC + 1) + int'(rd_j_i)];
    else
      rd_next = '0;
    if (reset_i) begin
      for (int k = 0; k < NC; k++) m_mem[k] = '0;
      m_full = 0; m_err = 0; m_fd = 0; m_pos = 0; m_rd = '0;
    end else begin
      m_rd = rd_next;
      m_fd = 0;
      if (clear_i) begin
        m_full = 0; m_pos = 0; m_err = 0;
      end else if (in_valid_i && !m_full) begin
        m_mem[m_pos] = in_data_i;
        if (m_pos == NC - 1) begin
          m_full = 1; m_fd = 1; m_pos = 0;
          if (!in_last_i) m_err = 1;
        end else if (in_last_i) begin
          m_err = 1; m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    n_tests++;
    if (in_ready_o !== 1'b1 || full_o !== 1'b0 || frame_done_o !== 1'b0 ||
        err_last_o !== 1'b0 || wr_i_o !== '0 || wr_j_o !== '0 || rd_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b full=%b fd=%b err=%b wr=(%0d,%0d) rd=%0h, required 1 0 0 0 (0,0) 0",
               in_ready_o, full_o, frame_done_o, err_last_o, wr_i_o, wr_j_o, rd_data_o);
    end
  endtask

  task automatic test_back_to_back();
    int rd_tab [3][3] = '{'{0, 0, 1}, '{1, 2, 6}, '{2, 2, 9}};
    for (int k = 1; k <= NC; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'(k);
      in_last_i  = (k == NC);
      tick();
      n_tests++;
      if (wr_i_o !== exp_i() || wr_j_o !== exp_j() || full_o !== m_full || frame_done_o !== m_fd) begin
        n_fail++;
        $display("FAIL b2b_step%0d: wr=(%0d,%0d) full=%b fd=%b, required (%0d,%0d) %b %b",
                 k, wr_i_o, wr_j_o, full_o, frame_done_o, exp_i(), exp_j(), m_full, m_fd);
      end
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    n_tests++;
    if (full_o !== 1'b1 || frame_done_o !== 1'b1 || in_ready_o !== 1'b0 || err_last_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full: full=%b fd=%b rdy=%b err=%b, required 1 1 0 0",
               full_o, frame_done_o, in_ready_o, err_last_o);
    end
    for (int r = 0; r < 3; r++) begin
      rd_i_i = W'(rd_tab[r][0]);
      rd_j_i = W'(rd_tab[r][1]);
      tick();
      n_tests++;
      if (rd_data_o !== DW'(rd_tab[r][2]) || frame_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_read(%0d,%0d): data=%0d fd=%b, required %0d 0",
                 rd_tab[r][0], rd_tab[r][1], rd_data_o, frame_done_o, rd_tab[r][2]);
      end
    end
  endtask

  task automatic test_toggle_valid();
    int cnt = 0;
    int cyc = 0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    while (cnt < NC && cyc < 40) begin
      in_valid_i = cyc[0];
      in_data_i  = DW'($urandom);
      in_last_i  = (cnt == NC - 1);
      if (in_valid_i) cnt++;
      cyc++;
      tick();
      n_tests++;
      if (wr_i_o !== exp_i() || wr_j_o !== exp_j() || full_o !== m_full) begin
        n_fail++;
        $display("FAIL toggle_cyc%0d: wr=(%0d,%0d) full=%b, required (%0d,%0d) %b",
                 cyc, wr_i_o, wr_j_o, full_o, exp_i(), exp_j(), m_full);
      end
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    n_tests++;
    if (full_o !== 1'b1 || wr_i_o !== '0 || wr_j_o !== '0) begin
      n_fail++;
      $display("FAIL toggle_end: full=%b wr=(%0d,%0d), required 1 (0,0)", full_o, wr_i_o, wr_j_o);
    end
    for (int c = 0; c < NC; c++) begin
      rd_i_i = W'(c / (SC + 1));
      rd_j_i = W'(c % (SC + 1));
      tick();
      n_tests++;
      if (rd_data_o !== m_rd) begin
        n_fail++;
        $display("FAIL toggle_read%0d: data=%0h, required %0h", c, rd_data_o, m_rd);
      end
    end
  endtask

  task automatic test_last_early();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'($urandom);
      in_last_i  = (k == 5);
      tick();
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    n_tests++;
    if (err_last_o !== 1'b1 || wr_i_o !== '0 || wr_j_o !== '0 || full_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL early_last: err=%b wr=(%0d,%0d) full=%b rdy=%b, required 1 (0,0) 0 1",
               err_last_o, wr_i_o, wr_j_o, full_o, in_ready_o);
    end
    for (int k = 11; k <= 19; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'(k);
      in_last_i  = (k == 19);
      tick();
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    rd_i_i = 2;
    rd_j_i = 2;
    tick();
    n_tests++;
    if (full_o !== 1'b1 || err_last_o !== 1'b1 || rd_data_o !== 8'd19) begin
      n_fail++;
      $display("FAIL early_refill: full=%b err=%b rd(2,2)=%0d, required 1 1 19",
               full_o, err_last_o, rd_data_o);
    end
  endtask

  task automatic test_full_hold();
    rd_i_i = 0;
    rd_j_i = 0;
    in_valid_i = 1'b1;
    in_data_i  = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (in_ready_o !== 1'b0 || full_o !== 1'b1 || rd_data_o !== 8'd11) begin
        n_fail++;
        $display("FAIL full_hold%0d: rdy=%b full=%b rd(0,0)=%0h, required 0 1 0b",
                 k, in_ready_o, full_o, rd_data_o);
      end
    end
    in_valid_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n_tests++;
    if (in_ready_o !== 1'b1 || full_o !== 1'b0 || err_last_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_release: rdy=%b full=%b err=%b, required 1 0 0", in_ready_o, full_o, err_last_o);
    end
    clear_i = 1'b1;
    in_valid_i = 1'b1;
    in_data_i = 8'h55;
    tick();
    clear_i = 1'b0;
    in_valid_i = 1'b0;
    tick();
    n_tests++;
    if (wr_i_o !== '0 || wr_j_o !== '0 || rd_data_o !== m_rd || rd_data_o !== 8'd11) begin
      n_fail++;
      $display("FAIL clear_drop: wr=(%0d,%0d) rd(0,0)=%0h, required (0,0) 0b", wr_i_o, wr_j_o, rd_data_o);
    end
  endtask

  task automatic test_read_range();
    logic [DW-1:0] old_v;
    rd_i_i = 3;
    rd_j_i = 0;
    tick();
    n_tests++;
    if (rd_data_o !== '0) begin
      n_fail++;
      $display("FAIL read_oor_row: data=%0h, required 0", rd_data_o);
    end
    rd_i_i = 0;
    rd_j_i = 3;
    tick();
    n_tests++;
    if (rd_data_o !== '0) begin
      n_fail++;
      $display("FAIL read_oor_col: data=%0h, required 0", rd_data_o);
    end
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'(8'h20 + k);
      tick();
    end
    old_v = m_mem[4];
    rd_i_i = 1;
    rd_j_i = 1;
    in_data_i = 8'h77;
    tick();
    in_valid_i = 1'b0;
    n_tests++;
    if (rd_data_o !== old_v || rd_data_o !== 8'd15) begin
      n_fail++;
      $display("FAIL read_during_write_old: data=%0h, required %0h", rd_data_o, old_v);
    end
    tick();
    n_tests++;
    if (rd_data_o !== 8'h77) begin
      n_fail++;
      $display("FAIL read_during_write_new: data=%0h, required 77", rd_data_o);
    end
  endtask

  task automatic test_reset_midfill();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'($urandom_range(1, 255));
      tick();
    end
    in_valid_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_tests++;
    if (wr_i_o !== '0 || wr_j_o !== '0 || full_o !== 1'b0 || rd_data_o !== '0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: wr=(%0d,%0d) full=%b rd=%0h rdy=%b, required (0,0) 0 0 1",
               wr_i_o, wr_j_o, full_o, rd_data_o, in_ready_o);
    end
    for (int c = 0; c < NC; c++) begin
      rd_i_i = W'(c / (SC + 1));
      rd_j_i = W'(c % (SC + 1));
      tick();
      n_tests++;
      if (rd_data_o !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_cell%0d: data=%0h, required 0", c, rd_data_o);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid_i = ($urandom % 4) != 0;
      in_data_i  = DW'($urandom);
      in_last_i  = (m_pos == NC - 1) ? (($urandom % 8) != 0) : (($urandom % 16) == 0);
      clear_i    = ($urandom % 24) == 0;
      rd_i_i     = W'($urandom % 4);
      rd_j_i     = W'($urandom % 4);
      tick();
      n_tests++;
      if (in_ready_o !== !m_full || full_o !== m_full || frame_done_o !== m_fd ||
          err_last_o !== m_err || wr_i_o !== exp_i() || wr_j_o !== exp_j() || rd_data_o !== m_rd) begin
        n_fail++;
        $display("FAIL random%0d: rdy=%b full=%b fd=%b err=%b wr=(%0d,%0d) rd=%0h, required %b %b %b %b (%0d,%0d) %0h",
                 n, in_ready_o, full_o, frame_done_o, err_last_o, wr_i_o, wr_j_o, rd_data_o,
                 !m_full, m_full, m_fd, m_err, exp_i(), exp_j(), m_rd);
      end
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    clear_i    = 1'b0;
  endtask

  initial begin
    reset_i    = 1'b1;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_last_i  = 1'b0;
    clear_i    = 1'b0;
    rd_i_i     = '0;
    rd_j_i     = '0;
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_last_early();
    test_full_hold();
    test_read_range();
    test_reset_midfill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_collector.md
# matrix_collector

Receiving end of the raster index stream in the ConvNet datapath: accepts matrix elements over a valid/ready handshake in row-major order, generates its own write indices (i, j) with the same sweep the feature-map index counter produces, and stores them in an internal register array. On the final element it freezes, flags the matrix full and serves random-access reads by (i, j) until the consumer releases it with `clear`. It sits between a streaming producer (convolution/pooling output) and the next layer's windowed reader.

## Interface
- SIZELin, 3, last row index; matrix has SIZELin+1 rows (0..SIZELin inclusive)
- SIZECol, 3, last column index; matrix has SIZECol+1 columns (0..SIZECol inclusive)
- WIDTH_BIT, 8, width of all index ports
- DATA_WIDTH, 8, element width

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer has an element
- in_ready  out  1  collector can accept
- in_data  in  DATA_WIDTH  element value
- in_last  in  1  producer marks final element of matrix
- clear  in  1  release FULL / abort current fill
- wr_i  out  WIDTH_BIT  row index of next element to be accepted
- wr_j  out  WIDTH_BIT  column index of next element to be accepted
- full  out  1  matrix complete, contents stable
- frame_done  out  1  one-cycle pulse when full rises
- err_last  out  1  sticky: in_last disagreed with internal position
- rd_i  in  WIDTH_BIT  read row
- rd_j  in  WIDTH_BIT  read column
- rd_data  out  DATA_WIDTH  registered read data

## Operation
- States: FILL, FULL. Reset -> FILL.
- Reset values: wr_i=0, wr_j=0, full=0, frame_done=0, err_last=0, rd_data=0, all array cells 0.
- in_ready = (state==FILL); combinational from state only, never from in_valid.
- Accept = in_valid & in_ready & !clear. On accept: mem[wr_i][wr_j] <= in_data; then index advance:
  - wr_j<SIZECol: wr_j+1, wr_i held.
  - wr_j==SIZECol, wr_i<SIZELin: wr_j=0, wr_i+1.
  - wr_j==SIZECol, wr_i==SIZELin (final): wr_i=wr_j=0, state -> FULL, full=1, frame_done=1.
- in_last check on accept:
  - final element with in_last=0: err_last set; still goes FULL.
  - non-final element with in_last=1: err_last set; indices resync to 0,0, stay FILL (truncated matrix discarded, stored cells not cleared).
- FULL: in_ready=0, array frozen, indices held at 0,0; in_valid ignored.
- clear (any state): next cycle state=FILL, wr_i=wr_j=0, full=0, err_last=0. Array contents retained. clear wins over a same-cycle accept: element dropped, no write, no index advance.
- Read: every cycle rd_data <= mem[rd_i][rd_j]; if rd_i>SIZELin or rd_j>SIZECol, rd_data <= 0. Reads valid in any state; read of a cell written in the same cycle returns the old value.
- Indices compared as unsigned WIDTH_BIT; SIZELin, SIZECol must be < 2^WIDTH_BIT.

## Timing
- Write latency: cell updated at the accepting edge; readable via rd_data 2 edges after acceptance (1 write, 1 read register).
- full rises on the edge that accepts the final element; frame_done high for exactly that following cycle.
- in_ready falls the cycle after final accept; rises the cycle after clear.
- Throughput: one element per cycle in FILL with in_valid held high; (SIZELin+1)(SIZECol+1) cycles per matrix, plus 1 cycle minimum in FULL before clear.
- reset mid-fill: all state and outputs return to reset values on the next edge; array zeroed.

## Test plan
- SIZELin=2, SIZECol=2, stream 1..9 back-to-back with in_last on 9th -> full=1 and frame_done pulse after 9th edge, in_ready=0, reads (0,0)=1, (1,2)=6, (2,2)=9, err_last=0.
- Same stream with in_valid toggling every other cycle -> identical contents; wr_i/wr_j advance only on accepted cycles (0,0)->(0,1)->...->(2,2)->(0,0).
- in_last asserted on 5th element -> err_last=1, wr_i=wr_j=0, full stays 0; then 9 clean elements 11..19 -> full=1, (2,2)=19, err_last still 1 until clear.
- FULL with in_valid=1, in_data=0xAA held 4 cycles -> no write, (0,0) unchanged; clear pulse -> next cycle in_ready=1, full=0, err_last=0; clear coinciding with an in_valid beat -> beat dropped, wr stays (0,0).
- Read out of range rd_i=3, rd_j=0 -> rd_data=0 next cycle; read (1,1) during FILL while it is written -> old value, new value one cycle later.
- reset asserted after 4 accepted elements -> next cycle wr_i=wr_j=0, full=0, rd_data=0, all cells read 0.
